// File: rtl/mem_access_wb.sv
// Memory-access / write-back stage: runs captured loads/stores on a req/ready data bus,
// aligns and extends load data, and merges it with forwarded ALU results on one write-back port.
module mem_access_wb #(
   parameter int unsigned BUS_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        mem_rden_i,
   input  logic        mem_wren_i,
   input  logic [31:0] mem_addr_i,
   input  logic [31:0] mem_wdata_i,
   input  logic [3:0]  mem_wstrb_i,
   input  logic [1:0]  mem_wordsize_i,
   input  logic        mem_signed_i,
   input  logic [5:0]  reg_id_i,
   input  logic [31:0] reg_data_i,
   input  logic        reg_data_valid_i,
   output logic        dbus_req_o,
   output logic        dbus_we_o,
   output logic [31:0] dbus_addr_o,
   output logic [31:0] dbus_wdata_o,
   output logic [3:0]  dbus_wstrb_o,
   input  logic        dbus_ready_i,
   input  logic [31:0] dbus_rdata_i,
   output logic        stall_o,
   output logic        wb_valid_o,
   output logic [5:0]  wb_id_o,
   output logic [31:0] wb_data_o,
   output logic        bus_err_o
);

   // Handshake: a bus transfer completes in the cycle where dbus_req_o & dbus_ready_i are both
   // high; dbus_req_o stays high until then (or until timeout) and addr/we/wdata/wstrb are stable.

   // The counter only ever holds 0 .. BUS_TIMEOUT-1.
   localparam int CW = (BUS_TIMEOUT < 2) ? 1 : $clog2(BUS_TIMEOUT);
   localparam logic [CW-1:0] TMO_LAST = CW'((BUS_TIMEOUT == 0) ? 0 : BUS_TIMEOUT - 1);

   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_BYTE = 2'd2;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [1:0]      off_q;
   logic [1:0]      size_q;
   logic            signed_q;
   logic [5:0]      id_q;

   logic            capture;
   logic            err_d;
   logic            wb_valid_d;
   logic [5:0]      wb_id_d;
   logic [31:0]     wb_data_d;

   function automatic logic is_misaligned(input logic [1:0] off, input logic [1:0] size);
      logic mis;
      case (size)
         SIZE_BYTE: mis = 1'b0;
         SIZE_HALF: mis = off[0];
         default:   mis = (off != 2'b00);
      endcase
      return mis;
   endfunction

   function automatic logic [31:0] align_load(input logic [31:0] rdata, input logic [1:0] off,
                                              input logic [1:0] size, input logic sgn);
      logic [31:0] res;
      logic [7:0]  b;
      logic [15:0] h;
      b = rdata[8*off +: 8];
      h = off[1] ? rdata[31:16] : rdata[15:0];
      case (size)
         SIZE_BYTE: res = {{24{sgn & b[7]}}, b};
         SIZE_HALF: res = {{16{sgn & h[15]}}, h};
         default:   res = rdata;
      endcase
      return res;
   endfunction

   assign dbus_req_o = (state_q == BUSY);
   assign stall_o    = (state_q != IDLE);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      capture    = 1'b0;
      err_d      = 1'b0;
      wb_valid_d = 1'b0;
      wb_id_d    = wb_id_o;
      wb_data_d  = wb_data_o;
      case (state_q)
         IDLE: begin
            if (mem_rden_i || mem_wren_i) begin
               if (is_misaligned(mem_addr_i[1:0], mem_wordsize_i)) begin
                  err_d = 1'b1;
               end else begin
                  capture = 1'b1;
                  state_d = BUSY;
                  cnt_d   = '0;
               end
            end else if (reg_data_valid_i) begin
               wb_valid_d = 1'b1;
               wb_id_d    = reg_id_i;
               wb_data_d  = reg_data_i;
            end
         end
         BUSY: begin
            if (dbus_ready_i) begin
               state_d = IDLE;
               if (!dbus_we_o) begin
                  wb_valid_d = 1'b1;
                  wb_id_d    = id_q;
                  wb_data_d  = align_load(dbus_rdata_i, off_q, size_q, signed_q);
               end
            end else if (BUS_TIMEOUT != 0) begin
               if (cnt_q == TMO_LAST) begin
                  state_d = IDLE;
                  err_d   = 1'b1;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Loads win over stores when both pulse, so the captured transfer is a read then.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         dbus_we_o    <= 1'b0;
         dbus_addr_o  <= '0;
         dbus_wdata_o <= '0;
         dbus_wstrb_o <= '0;
         off_q        <= '0;
         size_q       <= '0;
         signed_q     <= 1'b0;
         id_q         <= '0;
         bus_err_o    <= 1'b0;
         wb_valid_o   <= 1'b0;
         wb_id_o      <= '0;
         wb_data_o    <= '0;
      end else begin
         if (capture) begin
            dbus_we_o    <= !mem_rden_i;
            dbus_addr_o  <= {mem_addr_i[31:2], 2'b00};
            dbus_wdata_o <= mem_rden_i ? 32'h0 : mem_wdata_i;
            dbus_wstrb_o <= mem_rden_i ? 4'b0000 : mem_wstrb_i;
            off_q        <= mem_addr_i[1:0];
            size_q       <= mem_wordsize_i;
            signed_q     <= mem_signed_i;
            id_q         <= reg_id_i;
         end
         bus_err_o  <= err_d;
         wb_valid_o <= wb_valid_d;
         wb_id_o    <= wb_id_d;
         wb_data_o  <= wb_data_d;
      end
   end

endmodule

// File: tb/tb_mem_access_wb.sv
// Directed bench for mem_access_wb: pass-through, load alignment, stores, misalignment,
// priority, busy behaviour, timeout and asynchronous reset.
module tb_mem_access_wb;

   logic        clk;
   logic        resetn;
   logic        mem_rden_i;
   logic        mem_wren_i;
   logic [31:0] mem_addr_i;
   logic [31:0] mem_wdata_i;
   logic [3:0]  mem_wstrb_i;
   logic [1:0]  mem_wordsize_i;
   logic        mem_signed_i;
   logic [5:0]  reg_id_i;
   logic [31:0] reg_data_i;
   logic        reg_data_valid_i;
   logic        dbus_req_o;
   logic        dbus_we_o;
   logic [31:0] dbus_addr_o;
   logic [31:0] dbus_wdata_o;
   logic [3:0]  dbus_wstrb_o;
   logic        dbus_ready_i;
   logic [31:0] dbus_rdata_i;
   logic        stall_o;
   logic        wb_valid_o;
   logic [5:0]  wb_id_o;
   logic [31:0] wb_data_o;
   logic        bus_err_o;

   int n_checks = 0;
   int n_pass   = 0;

   mem_access_wb #(.BUS_TIMEOUT(4)) dut (
      .clk(clk), .resetn(resetn),
      .mem_rden_i(mem_rden_i), .mem_wren_i(mem_wren_i), .mem_addr_i(mem_addr_i),
      .mem_wdata_i(mem_wdata_i), .mem_wstrb_i(mem_wstrb_i), .mem_wordsize_i(mem_wordsize_i),
      .mem_signed_i(mem_signed_i), .reg_id_i(reg_id_i), .reg_data_i(reg_data_i),
      .reg_data_valid_i(reg_data_valid_i),
      .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
      .dbus_wdata_o(dbus_wdata_o), .dbus_wstrb_o(dbus_wstrb_o), .dbus_ready_i(dbus_ready_i),
      .dbus_rdata_i(dbus_rdata_i), .stall_o(stall_o),
      .wb_valid_o(wb_valid_o), .wb_id_o(wb_id_o), .wb_data_o(wb_data_o), .bus_err_o(bus_err_o)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // load vectors: address, size, signed, bus read data, expected write-back data
   logic [31:0] ld_addr  [7] = '{32'h103, 32'h101, 32'h206, 32'h204, 32'h400, 32'h408, 32'h102};
   logic [1:0]  ld_size  [7] = '{2'd2, 2'd2, 2'd1, 2'd1, 2'd0, 2'd3, 2'd2};
   logic        ld_sgn   [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
   logic [31:0] ld_rdata [7] = '{32'h80FF_0000, 32'h0000_AB00, 32'h8001_7FFF, 32'h8001_7FFF,
                                 32'hDEAD_BEEF, 32'h1234_5678, 32'h007F_0000};
   logic [31:0] ld_exp   [7] = '{32'hFFFF_FF80, 32'h0000_00AB, 32'hFFFF_8001, 32'h0000_7FFF,
                                 32'hDEAD_BEEF, 32'h1234_5678, 32'h0000_007F};

   // drive one cycle of upstream inputs starting at a falling edge; returns at the next falling
   // edge (cycle T+1) with all request inputs deasserted
   task automatic drive_op(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb,
                           input logic [1:0] size, input logic sgn, input logic [5:0] id,
                           input logic rv, input logic [31:0] rdat);
      @(negedge clk);
      mem_rden_i       = rd;
      mem_wren_i       = wr;
      mem_addr_i       = addr;
      mem_wdata_i      = wdata;
      mem_wstrb_i      = strb;
      mem_wordsize_i   = size;
      mem_signed_i     = sgn;
      reg_id_i         = id;
      reg_data_valid_i = rv;
      reg_data_i       = rdat;
      @(negedge clk);
      mem_rden_i       = 1'b0;
      mem_wren_i       = 1'b0;
      reg_data_valid_i = 1'b0;
   endtask

   task automatic test_reset;
      resetn = 1'b0;
      mem_rden_i = 0; mem_wren_i = 0; mem_addr_i = 0; mem_wdata_i = 0; mem_wstrb_i = 0;
      mem_wordsize_i = 0; mem_signed_i = 0; reg_id_i = 0; reg_data_i = 0; reg_data_valid_i = 0;
      dbus_ready_i = 0; dbus_rdata_i = 0;
      #12;
      n_checks++;
      if ({dbus_req_o, dbus_we_o, dbus_addr_o, dbus_wdata_o, dbus_wstrb_o, stall_o, wb_valid_o,
           wb_id_o, wb_data_o, bus_err_o} !== '0)
         $display("FAIL reset_outputs: got req=%0b stall=%0b wb_valid=%0b wb_data=%h err=%0b, need all 0",
                  dbus_req_o, stall_o, wb_valid_o, wb_data_o, bus_err_o);
      else n_pass++;
      @(negedge clk);
      resetn = 1'b1;
   endtask

   task automatic test_passthrough;
      drive_op(0, 0, 32'h0, 32'h0, 4'h0, 2'd0, 0, 6'd5, 1, 32'h1234);
      n_checks++;
      if ({wb_valid_o, wb_id_o, wb_data_o} !== {1'b1, 6'd5, 32'h1234})
         $display("FAIL pass_wb: got v=%0b id=%0d d=%h, need v=1 id=5 d=00001234",
                  wb_valid_o, wb_id_o, wb_data_o);
      else n_pass++;
      n_checks++;
      if ({dbus_req_o, stall_o} !== 2'b00)
         $display("FAIL pass_noreq: got req=%0b stall=%0b, need 0 0", dbus_req_o, stall_o);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if ({wb_valid_o, wb_data_o} !== {1'b0, 32'h1234})
         $display("FAIL pass_hold: got v=%0b d=%h, need v=0 d=00001234", wb_valid_o, wb_data_o);
      else n_pass++;
   endtask

   task automatic test_load_align;
      for (int i = 0; i < 7; i++) begin
         drive_op(1, 0, ld_addr[i], 32'h0, 4'hF, ld_size[i], ld_sgn[i], 6'(10 + i), 0, 32'h0);
         n_checks++;
         if ({dbus_req_o, dbus_we_o, dbus_addr_o, dbus_wstrb_o, stall_o, wb_valid_o} !==
             {1'b1, 1'b0, ld_addr[i] & 32'hFFFF_FFFC, 4'h0, 1'b1, 1'b0})
            $display("FAIL load%0d_req: got req=%0b we=%0b a=%h s=%h stall=%0b wbv=%0b, need 1 0 %h 0 1 0",
                     i, dbus_req_o, dbus_we_o, dbus_addr_o, dbus_wstrb_o, stall_o, wb_valid_o,
                     ld_addr[i] & 32'hFFFF_FFFC);
         else n_pass++;
         dbus_rdata_i = ld_rdata[i];
         dbus_ready_i = 1'b1;
         @(negedge clk);
         dbus_ready_i = 1'b0;
         n_checks++;
         if ({wb_valid_o, wb_id_o, wb_data_o, dbus_req_o, stall_o} !==
             {1'b1, 6'(10 + i), ld_exp[i], 1'b0, 1'b0})
            $display("FAIL load%0d_wb: got v=%0b id=%0d d=%h req=%0b stall=%0b, need 1 %0d %h 0 0",
                     i, wb_valid_o, wb_id_o, wb_data_o, dbus_req_o, stall_o, 10 + i, ld_exp[i]);
         else n_pass++;
      end
   endtask

   task automatic test_lhu_wait;
      int stall_cycles;
      stall_cycles = 0;
      drive_op(1, 0, 32'h202, 32'h0, 4'h0, 2'd1, 0, 6'd21, 0, 32'h0);
      dbus_rdata_i = 32'hBEEF_1234;
      for (int i = 0; i < 6; i++) begin
         if (stall_o) stall_cycles++;
         if (i == 3) dbus_ready_i = 1'b1;
         @(negedge clk);
         dbus_ready_i = 1'b0;
         if (wb_valid_o) break;
      end
      n_checks++;
      if (stall_cycles !== 4)
         $display("FAIL lhu_stall_len: got %0d cycles, need 4", stall_cycles);
      else n_pass++;
      n_checks++;
      if ({wb_valid_o, wb_id_o, wb_data_o, stall_o} !== {1'b1, 6'd21, 32'h0000_BEEF, 1'b0})
         $display("FAIL lhu_wb: got v=%0b id=%0d d=%h stall=%0b, need 1 21 0000beef 0",
                  wb_valid_o, wb_id_o, wb_data_o, stall_o);
      else n_pass++;
   endtask

   task automatic test_store;
      drive_op(0, 1, 32'h300, 32'hCAFE_F00D, 4'hF, 2'd0, 0, 6'd2, 0, 32'h0);
      n_checks++;
      if ({dbus_req_o, dbus_we_o, dbus_addr_o, dbus_wdata_o, dbus_wstrb_o} !==
          {1'b1, 1'b1, 32'h300, 32'hCAFE_F00D, 4'hF})
         $display("FAIL store_req: got req=%0b we=%0b a=%h d=%h s=%h, need 1 1 00000300 cafef00d f",
                  dbus_req_o, dbus_we_o, dbus_addr_o, dbus_wdata_o, dbus_wstrb_o);
      else n_pass++;
      dbus_ready_i = 1'b1;
      @(negedge clk);
      dbus_ready_i = 1'b0;
      n_checks++;
      if ({wb_valid_o, dbus_req_o, stall_o, bus_err_o} !== 4'b0000)
         $display("FAIL store_done: got wbv=%0b req=%0b stall=%0b err=%0b, need 0 0 0 0",
                  wb_valid_o, dbus_req_o, stall_o, bus_err_o);
      else n_pass++;
   endtask

   task automatic test_misaligned;
      logic [31:0] a [3] = '{32'h401, 32'h201, 32'h303};
      logic [1:0]  s [3] = '{2'd0, 2'd1, 2'd1};
      logic        w [3] = '{1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 3; i++) begin
         drive_op(!w[i], w[i], a[i], 32'h1, 4'h3, s[i], 0, 6'd4, 0, 32'h0);
         n_checks++;
         if ({bus_err_o, dbus_req_o, stall_o, wb_valid_o} !== 4'b1000)
            $display("FAIL misalign%0d_err: got err=%0b req=%0b stall=%0b wbv=%0b, need 1 0 0 0",
                     i, bus_err_o, dbus_req_o, stall_o, wb_valid_o);
         else n_pass++;
         @(negedge clk);
         n_checks++;
         if ({bus_err_o, dbus_req_o, stall_o, wb_valid_o} !== 4'b0000)
            $display("FAIL misalign%0d_after: got err=%0b req=%0b stall=%0b wbv=%0b, need 0 0 0 0",
                     i, bus_err_o, dbus_req_o, stall_o, wb_valid_o);
         else n_pass++;
      end
   endtask

   task automatic test_priority;
      drive_op(1, 1, 32'h700, 32'hFFFF_FFFF, 4'hF, 2'd0, 0, 6'd8, 1, 32'h55);
      n_checks++;
      if ({dbus_req_o, dbus_we_o, dbus_wstrb_o, wb_valid_o} !== {1'b1, 1'b0, 4'h0, 1'b0})
         $display("FAIL prio_rd: got req=%0b we=%0b s=%h wbv=%0b, need 1 0 0 0",
                  dbus_req_o, dbus_we_o, dbus_wstrb_o, wb_valid_o);
      else n_pass++;
      dbus_rdata_i = 32'h0BAD_F00D;
      dbus_ready_i = 1'b1;
      @(negedge clk);
      dbus_ready_i = 1'b0;
      n_checks++;
      if ({wb_valid_o, wb_id_o, wb_data_o} !== {1'b1, 6'd8, 32'h0BAD_F00D})
         $display("FAIL prio_rd_wb: got v=%0b id=%0d d=%h, need 1 8 0badf00d",
                  wb_valid_o, wb_id_o, wb_data_o);
      else n_pass++;
      drive_op(0, 1, 32'h704, 32'hA5A5_A5A5, 4'h3, 2'd0, 0, 6'd9, 1, 32'h66);
      n_checks++;
      if ({dbus_req_o, dbus_we_o, dbus_wstrb_o, wb_valid_o} !== {1'b1, 1'b1, 4'h3, 1'b0})
         $display("FAIL prio_wr: got req=%0b we=%0b s=%h wbv=%0b, need 1 1 3 0",
                  dbus_req_o, dbus_we_o, dbus_wstrb_o, wb_valid_o);
      else n_pass++;
      dbus_ready_i = 1'b1;
      @(negedge clk);
      dbus_ready_i = 1'b0;
   endtask

   task automatic test_back_to_back;
      drive_op(1, 0, 32'h600, 32'h0, 4'h0, 2'd0, 0, 6'd7, 0, 32'h0);
      // new requests while busy must be ignored
      mem_rden_i = 1'b1; mem_addr_i = 32'h900; reg_data_valid_i = 1'b1;
      reg_id_i = 6'd9; reg_data_i = 32'h99;
      @(negedge clk);
      mem_rden_i = 1'b0; reg_data_valid_i = 1'b0;
      n_checks++;
      if ({wb_valid_o, dbus_req_o, dbus_addr_o} !== {1'b0, 1'b1, 32'h600})
         $display("FAIL busy_ignore: got wbv=%0b req=%0b a=%h, need 0 1 00000600",
                  wb_valid_o, dbus_req_o, dbus_addr_o);
      else n_pass++;
      dbus_rdata_i = 32'h1111_2222;
      dbus_ready_i = 1'b1;
      @(negedge clk);
      dbus_ready_i = 1'b0;
      n_checks++;
      if ({wb_valid_o, wb_id_o, wb_data_o} !== {1'b1, 6'd7, 32'h1111_2222})
         $display("FAIL b2b_load_wb: got v=%0b id=%0d d=%h, need 1 7 11112222",
                  wb_valid_o, wb_id_o, wb_data_o);
      else n_pass++;
      // pass-through in the first idle cycle after the load
      mem_addr_i = 32'h0; reg_data_valid_i = 1'b1; reg_id_i = 6'd3; reg_data_i = 32'h33;
      @(negedge clk);
      reg_data_valid_i = 1'b0;
      n_checks++;
      if ({wb_valid_o, wb_id_o, wb_data_o} !== {1'b1, 6'd3, 32'h33})
         $display("FAIL b2b_pass_wb: got v=%0b id=%0d d=%h, need 1 3 00000033",
                  wb_valid_o, wb_id_o, wb_data_o);
      else n_pass++;
   endtask

   task automatic test_timeout;
      int req_cycles;
      req_cycles = 0;
      drive_op(1, 0, 32'h500, 32'h0, 4'h0, 2'd0, 0, 6'd12, 0, 32'h0);
      for (int i = 0; i < 4; i++) begin
         if (dbus_req_o && !bus_err_o) req_cycles++;
         @(negedge clk);
      end
      n_checks++;
      if (req_cycles !== 4)
         $display("FAIL tmo_req_len: got %0d cycles, need 4", req_cycles);
      else n_pass++;
      n_checks++;
      if ({dbus_req_o, bus_err_o, stall_o, wb_valid_o} !== 4'b0100)
         $display("FAIL tmo_err: got req=%0b err=%0b stall=%0b wbv=%0b, need 0 1 0 0",
                  dbus_req_o, bus_err_o, stall_o, wb_valid_o);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if ({bus_err_o, wb_valid_o} !== 2'b00)
         $display("FAIL tmo_after: got err=%0b wbv=%0b, need 0 0", bus_err_o, wb_valid_o);
      else n_pass++;
   endtask

   task automatic test_reset_mid_busy;
      drive_op(1, 0, 32'h800, 32'h0, 4'h0, 2'd0, 0, 6'd13, 0, 32'h0);
      n_checks++;
      if (dbus_req_o !== 1'b1)
         $display("FAIL rst_pre_req: got %0b, need 1", dbus_req_o);
      else n_pass++;
      #2 resetn = 1'b0;
      #1;
      n_checks++;
      if ({dbus_req_o, stall_o, wb_valid_o, wb_data_o} !== {3'b000, 32'h0})
         $display("FAIL rst_async: got req=%0b stall=%0b wbv=%0b d=%h, need 0 0 0 0",
                  dbus_req_o, stall_o, wb_valid_o, wb_data_o);
      else n_pass++;
      dbus_rdata_i = 32'h7777_7777;
      dbus_ready_i = 1'b1;
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      dbus_ready_i = 1'b0;
      n_checks++;
      if ({dbus_req_o, wb_valid_o, bus_err_o} !== 3'b000)
         $display("FAIL rst_abandon: got req=%0b wbv=%0b err=%0b, need 0 0 0",
                  dbus_req_o, wb_valid_o, bus_err_o);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_passthrough();
      test_load_align();
      test_lhu_wait();
      test_store();
      test_misaligned();
      test_priority();
      test_back_to_back();
      test_timeout();
      test_reset_mid_busy();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
